// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared state encoding and Q1.15 constants for the ANC controller
package anc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } anc_state_t;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  localparam int TIMEOUT_CYCLES_DEF = 300;

endpackage

// File: rtl/anc_ctrl_sat.sv
// rtl/anc_ctrl_sat.sv - clamps a 17-bit signed value into the Q1.15 range
module anc_ctrl_sat
  import anc_pkg::*;
(
  input  logic signed [16:0] din,
  output logic signed [15:0] dout
);

  always_comb begin
    if (din > 17'(Q15_MAX)) begin
      dout = Q15_MAX;
    end else if (din < 17'(Q15_MIN)) begin
      dout = Q15_MIN;
    end else begin
      dout = din[15:0];
    end
  end

endmodule

// File: rtl/anc_ctrl.sv
// rtl/anc_ctrl.sv - ANC sample controller: buffers mic pairs, launches the filter,
// forwards results to the DAC and mutes on a hung filter run
module anc_ctrl
  import anc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [15:0]      ref_sample,
  input  logic signed [15:0]      err_sample,
  input  logic                    sample_valid,
  input  logic                    adapt_en,
  input  logic        [3:0]       mu_shift,
  input  logic signed [15:0]      dc_offset,
  input  logic                    err_clr,
  output logic signed [15:0]      fir_x_in,
  output logic signed [15:0]      fir_a_in,
  output logic signed [15:0]      fir_weight_adjust,
  output logic                    fir_go,
  input  logic signed [15:0]      fir_out_sample,
  input  logic                    fir_done,
  output logic signed [15:0]      dac_sample,
  output logic                    dac_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic        [CNT_W-1:0] sample_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  anc_state_t         state;
  logic               pend_v;
  logic signed [15:0] pend_ref;
  logic signed [15:0] pend_err;
  logic [TW-1:0]      tcnt;
  logic [TW-1:0]      tcnt_inc;
  logic signed [15:0] err_shr;
  logic signed [16:0] err_ext;
  logic signed [16:0] wadj_raw;
  logic signed [15:0] wadj;
  logic               consume;
  logic               ovr_set;
  logic               tmo_hit;
  logic               tmo_set;

  assign consume  = (state == S_IDLE) && pend_v;
  assign ovr_set  = sample_valid && pend_v && !consume;
  assign err_shr  = pend_err >>> mu_shift;
  assign err_ext  = 17'(err_shr);
  assign wadj_raw = adapt_en ? -err_ext : '0;

  // The run is declared hung on the edge where the counter would reach its last value.
  assign tcnt_inc = tcnt + TW'(1);
  assign tmo_hit  = (tcnt_inc == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_set  = (state == S_WAIT) && !fir_done && tmo_hit;

  anc_ctrl_sat u_sat (
    .din  (wadj_raw),
    .dout (wadj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      pend_v            <= 1'b0;
      pend_ref          <= '0;
      pend_err          <= '0;
      tcnt              <= '0;
      fir_x_in          <= '0;
      fir_a_in          <= '0;
      fir_weight_adjust <= '0;
      fir_go            <= 1'b0;
      dac_sample        <= '0;
      dac_valid         <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
      sample_cnt        <= '0;
    end else begin
      fir_go    <= 1'b0;
      dac_valid <= 1'b0;

      // Newest pair always wins the single-entry buffer.
      if (sample_valid) begin
        pend_v   <= 1'b1;
        pend_ref <= ref_sample;
        pend_err <= err_sample;
      end else if (consume) begin
        pend_v <= 1'b0;
      end

      overrun     <= ovr_set || (overrun && !err_clr);
      timeout_err <= tmo_set || (timeout_err && !err_clr);

      case (state)
        S_IDLE: begin
          if (pend_v) begin
            fir_x_in          <= pend_ref;
            fir_a_in          <= dc_offset;
            fir_weight_adjust <= wadj;
            fir_go            <= 1'b1;
            busy              <= 1'b1;
            state             <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fir_done) begin
            dac_sample <= fir_out_sample;
            dac_valid  <= 1'b1;
            sample_cnt <= sample_cnt + CNT_W'(1);
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (tmo_hit) begin
            dac_sample <= '0;
            dac_valid  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anc_ctrl.sv
// tb/tb_anc_ctrl.sv - self-checking bench for anc_ctrl with a timestamp-based reference model
module tb_anc_ctrl;

  localparam int TO = 300;

  logic        clk;
  logic        rst_n;
  logic [15:0] ref_sample;
  logic [15:0] err_sample;
  logic        sample_valid;
  logic        adapt_en;
  logic [3:0]  mu_shift;
  logic [15:0] dc_offset;
  logic        err_clr;
  logic [15:0] fir_x_in;
  logic [15:0] fir_a_in;
  logic [15:0] fir_weight_adjust;
  logic        fir_go;
  logic [15:0] fir_out_sample;
  logic        fir_done;
  logic [15:0] dac_sample;
  logic        dac_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] sample_cnt;

  anc_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ref_sample        (ref_sample),
    .err_sample        (err_sample),
    .sample_valid      (sample_valid),
    .adapt_en          (adapt_en),
    .mu_shift          (mu_shift),
    .dc_offset         (dc_offset),
    .err_clr           (err_clr),
    .fir_x_in          (fir_x_in),
    .fir_a_in          (fir_a_in),
    .fir_weight_adjust (fir_weight_adjust),
    .fir_go            (fir_go),
    .fir_out_sample    (fir_out_sample),
    .fir_done          (fir_done),
    .dac_sample        (dac_sample),
    .dac_valid         (dac_valid),
    .busy              (busy),
    .overrun           (overrun),
    .timeout_err       (timeout_err),
    .sample_cnt        (sample_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int go_cnt   = 0;
  int dv_cnt   = 0;
  bit cmp_en   = 0;

  // filter stand-in controls
  int          lat      = 2;
  bit          rand_lat = 0;
  bit          rand_out = 0;
  bit          spur_en  = 0;
  logic [15:0] f_val    = 16'h0000;

  // reference model state
  bit          m_run, m_pv;
  int          m_g;
  logic [15:0] m_ref, m_err;
  logic        exp_go, exp_dv, exp_busy, exp_ovr, exp_tmo;
  logic [15:0] exp_ds, exp_x, exp_a, exp_w, exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] ref_wadj(input logic [15:0] e, input logic [3:0] mu, input logic en);
    int ev;
    int v;
    if (!en) return 16'h0000;
    ev = int'($signed(e));
    v  = -(ev >>> mu);
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  // Model: a launch at edge g owns the filter until a done seen at edges g+2..g+TO, else it mutes at g+TO.
  initial begin
    bit idle_pre, pv_pre, consume, tset;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_pv = 0; m_g = 0; m_ref = '0; m_err = '0;
        exp_go = 0; exp_dv = 0; exp_busy = 0; exp_ovr = 0; exp_tmo = 0;
        exp_ds = '0; exp_x = '0; exp_a = '0; exp_w = '0; exp_cnt = '0;
      end else begin
        cyc++;
        idle_pre = !m_run;
        pv_pre   = m_pv;
        consume  = idle_pre && pv_pre;
        tset     = 0;
        exp_go   = 0;
        exp_dv   = 0;
        if (m_run && cyc >= m_g + 2 && fir_done) begin
          exp_dv = 1; exp_ds = fir_out_sample; exp_cnt = exp_cnt + 16'd1; m_run = 0;
        end else if (m_run && cyc == m_g + TO) begin
          exp_dv = 1; exp_ds = 16'h0000; tset = 1; m_run = 0;
        end
        if (consume) begin
          exp_go = 1; exp_x = m_ref; exp_a = dc_offset;
          exp_w  = ref_wadj(m_err, mu_shift, adapt_en);
          m_run  = 1; m_g = cyc; m_pv = 0;
        end
        exp_ovr = (sample_valid && pv_pre && !consume) || (exp_ovr && !err_clr);
        exp_tmo = tset || (exp_tmo && !err_clr);
        if (sample_valid) begin
          m_pv = 1; m_ref = ref_sample; m_err = err_sample;
        end
        exp_busy = m_run;
      end
    end
  end

  // Filter stand-in: done pulse `lat` cycles after fir_go (lat 0 = never).
  initial begin
    int cd;
    int l;
    cd = 0;
    fir_done = 0;
    fir_out_sample = '0;
    forever begin
      @(negedge clk);
      fir_done = 0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        fir_out_sample = rand_out ? 16'($urandom) : f_val;
        if (cd > 0) begin
          cd--;
          if (cd == 0) fir_done = 1;
        end
        if (spur_en && $urandom_range(0, 59) == 0) fir_done = 1;
        if (fir_go) begin
          l = lat;
          if (rand_lat) l = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 8));
          cd = l;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        if (fir_go) go_cnt++;
        if (dac_valid) dv_cnt++;
        chk("fir_go", fir_go, exp_go);
        chk("dac_valid", dac_valid, exp_dv);
        chk("dac_sample", dac_sample, exp_ds);
        chk("fir_x_in", fir_x_in, exp_x);
        chk("fir_a_in", fir_a_in, exp_a);
        chk("fir_weight_adjust", fir_weight_adjust, exp_w);
        chk("busy", busy, exp_busy);
        chk("overrun", overrun, exp_ovr);
        chk("timeout_err", timeout_err, exp_tmo);
        chk("sample_cnt", sample_cnt, exp_cnt);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [15:0] r, input logic [15:0] e, output int s);
    ref_sample   = r;
    err_sample   = e;
    sample_valid = 1;
    s = cyc;
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic wait_go(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge clk);
      if (fir_go) at = cyc;
    end
    if (at < 0) chk("wait_go_bound", fir_go, 1);
  endtask

  task automatic wait_dv(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge clk);
      if (dac_valid) at = cyc;
    end
    if (at < 0) chk("wait_dv_bound", dac_valid, 1);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 800 && quiet < 3; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 3) chk("wait_idle_bound", busy, 0);
  endtask

  initial begin
    int s, g, d, c0, gc0, dc0;
    rst_n = 0; ref_sample = '0; err_sample = '0; sample_valid = 0;
    adapt_en = 0; mu_shift = '0; dc_offset = '0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 32'(|{fir_x_in, fir_a_in, fir_weight_adjust, fir_go, dac_sample,
                                   dac_valid, busy, overrun, timeout_err, sample_cnt}), 0);
    rst_n = 1;
    cmp_en = 1;
    repeat (2) @(negedge clk);

    // basic adapted run
    adapt_en = 1; mu_shift = 4'd4; dc_offset = 16'h0000; lat = 3; f_val = 16'h1234;
    strobe(16'h0400, 16'h1000, s);
    wait_go(10, g);
    chk("s1_go_latency", g - s, 2);
    chk("s1_weight_adjust", fir_weight_adjust, 16'hFF00);
    chk("s1_x_in", fir_x_in, 16'h0400);
    wait_dv(20, d);
    chk("s1_dv_latency", d - g, 4);
    chk("s1_dac_sample", dac_sample, 16'h1234);
    chk("s1_sample_cnt", sample_cnt, 16'd1);
    wait_idle();

    // saturating negate, then frozen weights
    mu_shift = 4'd0; dc_offset = 16'h0123;
    strobe(16'h1111, 16'h8000, s);
    wait_go(10, g);
    chk("s2_weight_sat", fir_weight_adjust, 16'h7FFF);
    chk("s2_a_in", fir_a_in, 16'h0123);
    wait_dv(20, d);
    wait_idle();
    adapt_en = 0;
    strobe(16'h1111, 16'h8000, s);
    wait_go(10, g);
    chk("s2_weight_frozen", fir_weight_adjust, 16'h0000);
    wait_dv(20, d);
    wait_idle();

    // three strobes while the filter runs: newest wins, overrun set then cleared
    adapt_en = 1; mu_shift = 4'd2; lat = 12;
    strobe(16'h0AAA, 16'h0001, s);
    wait_go(10, g);
    strobe(16'h0B01, 16'h0002, s);
    strobe(16'h0B02, 16'h0003, s);
    strobe(16'h0B03, 16'h0100, s);
    chk("s3_overrun_set", overrun, 1);
    wait_dv(30, d);
    wait_go(10, g);
    chk("s3_third_pair_x", fir_x_in, 16'h0B03);
    chk("s3_third_pair_w", fir_weight_adjust, 16'hFFC0);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("s3_overrun_cleared", overrun, 0);
    wait_dv(30, d);
    wait_idle();

    // strobe coincident with fir_done
    lat = 3;
    gc0 = go_cnt; dc0 = dv_cnt;
    strobe(16'h0C00, 16'h0040, s);
    wait_go(10, g);
    repeat (3) @(negedge clk);
    ref_sample = 16'h0C01; sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    repeat (15) @(negedge clk);
    chk("s4_go_pulses", go_cnt - gc0, 2);
    chk("s4_dv_pulses", dv_cnt - dc0, 2);
    chk("s4_no_overrun", overrun, 0);
    wait_idle();

    // hung filter: mute output after the timeout
    lat = 0; f_val = 16'h5555;
    c0 = sample_cnt;
    strobe(16'h0D00, 16'h0000, s);
    wait_go(10, g);
    wait_dv(TO + 50, d);
    chk("s5_timeout_latency", d - g, TO);
    chk("s5_mute_sample", dac_sample, 16'h0000);
    chk("s5_timeout_err", timeout_err, 1);
    chk("s5_cnt_unchanged", sample_cnt, c0);
    lat = 2;
    strobe(16'h0D01, 16'h0000, s);
    wait_go(10, g);
    chk("s5_relaunch_latency", g - s, 2);
    wait_dv(20, d);
    chk("s5_relaunch_sample", dac_sample, 16'h5555);
    chk("s5_relaunch_cnt", sample_cnt, 16'(c0 + 1));
    wait_idle();

    // randomized traffic
    rand_lat = 1; rand_out = 1; spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      sample_valid = ($urandom_range(0, 5) == 0);
      ref_sample   = 16'($urandom);
      err_sample   = 16'($urandom);
      adapt_en     = ($urandom_range(0, 3) != 0);
      mu_shift     = 4'($urandom);
      dc_offset    = 16'($urandom);
      err_clr      = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    sample_valid = 0; err_clr = 0; spur_en = 0; rand_lat = 0; rand_out = 0; lat = 2;
    wait_idle();

    // reset in the middle of a run
    lat = 0;
    strobe(16'h0E00, 16'h0000, s);
    wait_go(10, g);
    repeat (5) @(negedge clk);
    dc0 = dv_cnt;
    #2 rst_n = 0;
    #1 chk("s6_reset_outputs_zero", 32'(|{fir_x_in, fir_a_in, fir_weight_adjust, fir_go, dac_sample,
                                          dac_valid, busy, overrun, timeout_err, sample_cnt}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    lat = 2; f_val = 16'h2468;
    repeat (4) @(negedge clk);
    chk("s6_no_dac_valid", dv_cnt - dc0, 0);
    chk("s6_cnt_zero", sample_cnt, 16'd0);
    strobe(16'h0E01, 16'h0000, s);
    wait_go(10, g);
    chk("s6_fresh_go_latency", g - s, 2);
    chk("s6_fresh_x_in", fir_x_in, 16'h0E01);
    wait_dv(20, d);
    chk("s6_fresh_sample", dac_sample, 16'h2468);
    chk("s6_fresh_cnt", sample_cnt, 16'd1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/anc_ctrl.md
ANC_CTRL -- requirements
Module: anc_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 300: maximum cycles spent in WAIT before the run is declared hung.
REQ-002 Parameter CNT_W, default 16: width of sample_cnt.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset: asynchronous, active-low.
REQ-005 ref_sample  in  16  signed Q1.15 reference-mic sample.
REQ-006 err_sample  in  16  signed Q1.15 error-mic sample, paired with ref_sample.
REQ-007 sample_valid  in  1  one-cycle strobe qualifying ref_sample and err_sample.
REQ-008 adapt_en  in  1  1 = adapt weights; 0 = freeze (weight adjust forced to 0).
REQ-009 mu_shift  in  4  step size; mu = 2^-mu_shift.
REQ-010 dc_offset  in  16  signed accumulator seed passed to the filter.
REQ-011 err_clr  in  1  one-cycle pulse clearing the sticky flags.
REQ-012 fir_x_in, fir_a_in, fir_weight_adjust  out  16 each  signed operands to the filter.
REQ-013 fir_go  out  1  one-cycle filter start pulse.
REQ-014 fir_out_sample  in  16  signed filter result.
REQ-015 fir_done  in  1  one-cycle filter-completion pulse.
REQ-016 dac_sample  out  16  signed anti-noise output.
REQ-017 dac_valid  out  1  one-cycle pulse qualifying dac_sample.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 overrun  out  1  sticky: an input pair was lost.
REQ-020 timeout_err  out  1  sticky: the filter failed to signal done in time.
REQ-021 sample_cnt  out  CNT_W  count of completed outputs; wraps modulo 2^CNT_W.

Function
REQ-022 FSM states IDLE, LAUNCH, WAIT; registered state; all outputs registered.
REQ-023 Pending buffer: one entry holding {ref, err} plus a valid bit.
- Every sample_valid writes the buffer.
- If the buffer is already valid and not being consumed in the same cycle, the write overwrites it (newest wins) and sets overrun.
REQ-024 IDLE: with pending valid, consume the entry and go to LAUNCH.
- In the same edge, latch fir_x_in = ref, fir_a_in = dc_offset, fir_weight_adjust = wadj.
- A sample_valid arriving in IDLE with pending empty is consumed through the buffer, giving fir_go two cycles after the strobe.
REQ-025 wadj calculation:
- adapt_en = 0: wadj = 0.
- adapt_en = 1: wadj = sat16(-(err >>> mu_shift)), with an arithmetic shift; negating -32768 saturates to +32767.
REQ-026 LAUNCH: fir_go = 1 for exactly one cycle, then go to WAIT.
REQ-027 fir_x_in, fir_a_in and fir_weight_adjust SHALL hold stable from LAUNCH until the next LAUNCH.
REQ-028 WAIT: timeout counter starts at 0 and increments each cycle.
- On fir_done: the next cycle has dac_sample = fir_out_sample, dac_valid = 1 and sample_cnt incremented; go to IDLE.
REQ-029 WAIT timeout: if the counter reaches TIMEOUT_CYCLES-1 without fir_done:
- set timeout_err;
- next cycle, dac_sample = 0 (mute) with dac_valid = 1, and sample_cnt is not incremented;
- go to IDLE.
REQ-030 fir_done outside WAIT SHALL be ignored.
REQ-031 fir_done and a timeout in the same cycle: treated as done (no timeout_err).
REQ-032 sample_valid in the same cycle as fir_done SHALL enter the pending buffer and be launched through IDLE with no loss.
REQ-033 err_clr clears overrun and timeout_err; a set event in the same cycle wins.
REQ-034 Throughput: one launch per input pair; the minimum sample period is the filter run time plus 3 cycles.

Reset
REQ-035 On rst_n low, SHALL immediately enter IDLE and force all of the following to 0:
- every output;
- the pending valid bit and the timeout counter;
- all latched operands.
REQ-036 Reset asserted mid-run SHALL abandon the run with no dac_valid; the first sample after release starts a fresh run.

Structure
REQ-037 A shared package anc_pkg SHALL hold:
- the state enumeration;
- the Q1.15 MIN/MAX constants;
- the default TIMEOUT_CYCLES.
REQ-038 The existing saturate sub-module (17-bit to 16-bit) SHALL be instantiated for wadj; no other sub-module.

Verification
REQ-039 Scenario: adapt_en = 1, mu_shift = 4, err = 0x1000, ref = 0x0400, dc_offset = 0. Required: fir_go 2 cycles after the strobe with fir_weight_adjust = 0xFF00 and fir_x_in = 0x0400; filter model returns 0x1234 → dac_sample = 0x1234 one cycle after fir_done; sample_cnt = 1.
REQ-040 Scenario: err = 0x8000, mu_shift = 0. Required: fir_weight_adjust = 0x7FFF. Same stimulus with adapt_en = 0 → fir_weight_adjust = 0.
REQ-041 Scenario: three strobes during WAIT. Required: overrun = 1; only the third pair launches after done; err_clr returns overrun to 0.
REQ-042 Scenario: sample_valid coincident with fir_done. Required: two dac_valid pulses and two fir_go pulses in total; overrun stays 0.
REQ-043 Scenario: filter model never asserts done, TIMEOUT_CYCLES = 300. Required: timeout_err = 1 and dac_valid with dac_sample = 0 exactly 300 cycles after fir_go; sample_cnt unchanged; next strobe launches normally.
REQ-044 Scenario: rst_n pulsed low mid-WAIT. Required: all outputs 0 immediately; no dac_valid; sample_cnt = 0.
